dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-master arbiter and sequencer for the single-port data memory (DMEM) of the RISC-V core. It shares the port between the CPU load/store path and a debug/loader port. Arbitration is round-robin, with a bounded debug lock for bursts. Read data returns with DMEM's 1-cycle latency and is steered to the master that issued the read. It sits between the CPU datapath's memory interface and the DMEM instance, and provides the stall signal the single-cycle core uses to hold its PC.

## Interface
- DATA_WIDTH, 32, data word width
- ADDR_WIDTH, 32, byte address width; passed to DMEM unchanged
- LOCK_MAX, 8, maximum consecutive locked debug grants (≥1)

One clock; reset is synchronous and active-high.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- cpu_req / cpu_we  in  1 / 1  CPU access request / write enable
- cpu_addr / cpu_wdata  in  ADDR_WIDTH / DATA_WIDTH  CPU address / write data
- cpu_gnt  out  1  CPU access accepted this cycle
- cpu_stall  out  1  cpu_req & ~cpu_gnt
- cpu_rvalid / cpu_rdata  out  1 / DATA_WIDTH  CPU read data valid / value
- dbg_req / dbg_we / dbg_lock  in  1 each  debug request / write enable / hold ownership
- dbg_addr / dbg_wdata  in  ADDR_WIDTH / DATA_WIDTH  debug address / write data
- dbg_gnt  out  1  debug access accepted
- dbg_rvalid / dbg_rdata  out  1 / DATA_WIDTH  debug read data valid / value
- mem_en / mem_we  out  1 / 1  DMEM enable / write
- mem_addr / mem_wdata  out  ADDR_WIDTH / DATA_WIDTH  DMEM address / write data
- mem_rdata  in  DATA_WIDTH  DMEM read data, valid the cycle after mem_en & ~mem_we

## Operation
- **Handshake:** a master holds req, we, addr and wdata stable until its gnt is high. The transfer occurs on the clock edge where gnt=1.
- **Grants:** at most one gnt per cycle. Grants are combinational from the req inputs and the registered state.
- **Memory port:** mem_en = cpu_gnt | dbg_gnt. mem_we, mem_addr and mem_wdata mux from the granted master. With no grant they are 0.
- **Reads:** the grant cycle of a read registers an owner tag.
  - The next cycle asserts rvalid for that owner only.
  - rdata = mem_rdata while the owner's rvalid is high, otherwise 0.
  - Writes never produce rvalid.
- **Round-robin:** a last_gnt register records the most recent granted master; reset value is DBG, so the CPU wins the first contention. With both requesting, the master that is not last_gnt wins. A lone requester always wins.
- **FSM:**
  - ARB: round-robin as above. Going to LOCKED requires a debug grant with dbg_lock=1; the lock counter is then set to 1.
  - LOCKED: dbg_gnt = dbg_req; CPU blocked.
    - Each debug grant increments the counter.
    - If dbg_lock or dbg_req drops, go to ARB; last_gnt = DBG.
    - If the counter reaches LOCK_MAX on a grant, go to FORCE_CPU.
  - FORCE_CPU: CPU has absolute priority; debug is granted only if cpu_req=0. Always return to ARB after one cycle with last_gnt set to the master granted, or unchanged if none.
- **Lock counter:** clog2(LOCK_MAX+1) bits; cleared in ARB.

## Timing
- Grant latency: 0 cycles (same cycle as req when arbitration is won). Read data latency: 1 cycle after grant.
- Back-to-back reads by alternating masters are allowed. rvalid/owner tag is a 1-deep pipeline, overwritten every cycle.
- **Simultaneous events:**
  - A read grant coincides with the previous read's rvalid cycle: both are correct, since the tags are independent per cycle.
  - dbg_lock drops in the same cycle as the LOCK_MAX grant: FORCE_CPU still taken.
- **Reset values:**
  - While reset is high, all gnt, mem_en, mem_we and rvalid outputs are 0, and rdata is 0.
  - After reset: state = ARB, last_gnt = DBG, counter = 0, owner-valid = 0.
- **Reset mid-operation:** a pending read's rvalid is discarded, an active lock is terminated, and no memory write occurs in the reset cycle.
- **LOCK_MAX=1:** every locked grant goes straight to FORCE_CPU.

## Structure
- Shared package `dmem_arb_pkg` holds:
  - typedef enum for FSM states {ARB, LOCKED, FORCE_CPU}
  - typedef enum for master id {MST_CPU, MST_DBG}
  - default width constants
- One natural sub-module: `rr_arb2`, a combinational two-requester round-robin picker, given req[1:0] and last_gnt and returning a one-hot grant. The FSM, counter and read-tag pipeline stay in the top level.

## Test plan
- Reset held 2 cycles with cpu_req=dbg_req=1 → no gnt, mem_en=0. First cycle after release → cpu_gnt=1, dbg_gnt=0.
- Both masters request continuously, no lock → grants alternate CPU, DBG, CPU, DBG. cpu_stall=1 exactly on DBG cycles.
- CPU writes 7 to addr 96, then debug reads addr 96 → DMEM[96]=7, dbg_rvalid=1 with dbg_rdata=7 the cycle after dbg_gnt, cpu_rvalid stays 0.
- LOCK_MAX=8, debug locked burst of 12 with cpu_req=1 → 8 consecutive dbg_gnt, then 1 cpu_gnt (FORCE_CPU), then arbitration resumes.
- Debug read granted, reset asserted the next cycle → dbg_rvalid=0 and state=ARB; the first contention after release grants the CPU.
- CPU read of addr 100 and a debug write of 25 to addr 100 in consecutive cycles → cpu_rdata is the old value, and a subsequent read returns 25.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and default widths for the DMEM arbiter
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ARB       = 2'd0,
    LOCKED    = 2'd1,
    FORCE_CPU = 2'd2
  } arb_state_e;

  typedef enum logic {
    MST_CPU = 1'b0,
    MST_DBG = 1'b1
  } mst_e;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_LOCK_MAX   = 8;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-requester round-robin picker, one-hot grant
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  mst_e       last_gnt,
  output logic [1:0] gnt
);

  // bit 0 = CPU, bit 1 = DBG; on contention the master that did not win last goes
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (last_gnt == MST_DBG) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU/debug arbiter and read-data steering for single-port DMEM
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int LOCK_MAX   = DEF_LOCK_MAX
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_stall,
  output logic                  cpu_rvalid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic                  dbg_lock,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  output logic                  dbg_gnt,
  output logic                  dbg_rvalid,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int CW = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] LOCK_CAP = CW'(LOCK_MAX);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  arb_state_e    state_q, state_d;
  mst_e          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0]    rr_gnt;
  logic          rd_vld_q;
  mst_e          rd_owner_q;

  rr_arb2 u_rr (
    .req      ({dbg_req, cpu_req}),
    .last_gnt (last_q),
    .gnt      (rr_gnt)
  );

  assign cnt_inc = cnt_q + CNT_ONE;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    case (state_q)
      ARB: begin
        cpu_gnt = rr_gnt[0];
        dbg_gnt = rr_gnt[1];
        cnt_d   = '0;
        if (rr_gnt[0]) last_d = MST_CPU;
        if (rr_gnt[1]) begin
          last_d = MST_DBG;
          if (dbg_lock) begin
            // a one-grant lock budget is already exhausted by this grant
            if (CNT_ONE == LOCK_CAP) begin
              state_d = FORCE_CPU;
            end else begin
              state_d = LOCKED;
              cnt_d   = CNT_ONE;
            end
          end
        end
      end
      LOCKED: begin
        dbg_gnt = dbg_req;
        last_d  = MST_DBG;
        if (dbg_req) begin
          cnt_d = cnt_inc;
          // budget exhaustion wins over a lock release in the same cycle
          if (cnt_inc == LOCK_CAP) begin
            state_d = FORCE_CPU;
            cnt_d   = '0;
          end else if (!dbg_lock) begin
            state_d = ARB;
            cnt_d   = '0;
          end
        end else begin
          state_d = ARB;
          cnt_d   = '0;
        end
      end
      FORCE_CPU: begin
        cpu_gnt = cpu_req;
        dbg_gnt = dbg_req & ~cpu_req;
        state_d = ARB;
        cnt_d   = '0;
        if (cpu_req)      last_d = MST_CPU;
        else if (dbg_req) last_d = MST_DBG;
      end
      default: begin
        state_d = ARB;
        cnt_d   = '0;
      end
    endcase
    if (reset) begin
      cpu_gnt = 1'b0;
      dbg_gnt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB;
      last_q  <= MST_DBG;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cpu_stall = cpu_req & ~cpu_gnt;

  assign mem_en    = cpu_gnt | dbg_gnt;
  assign mem_we    = cpu_gnt ? cpu_we    : (dbg_gnt ? dbg_we    : 1'b0);
  assign mem_addr  = cpu_gnt ? cpu_addr  : (dbg_gnt ? dbg_addr  : '0);
  assign mem_wdata = cpu_gnt ? cpu_wdata : (dbg_gnt ? dbg_wdata : '0);

  // one-deep owner tag for the read issued in the previous cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_vld_q   <= 1'b0;
      rd_owner_q <= MST_CPU;
    end else begin
      rd_vld_q   <= mem_en & ~mem_we;
      rd_owner_q <= dbg_gnt ? MST_DBG : MST_CPU;
    end
  end

  assign cpu_rvalid = ~reset & rd_vld_q & (rd_owner_q == MST_CPU);
  assign dbg_rvalid = ~reset & rd_vld_q & (rd_owner_q == MST_DBG);
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
  assign dbg_rdata  = dbg_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter with DMEM and reference model
module tb_dmem_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int LM = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt, cpu_stall, cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          dbg_req, dbg_we, dbg_lock;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_gnt, dbg_rvalid;
  logic [DW-1:0] dbg_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_clear;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LOCK_MAX(LM)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_lock(dbg_lock), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // DMEM stand-in: 64 words, one-cycle read latency
  logic [DW-1:0] dmem [0:63];
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 64; i++) dmem[i] <= '0;
    end else if (mem_en) begin
      if (mem_we) dmem[mem_addr[7:2]] <= mem_wdata;
      else        mem_rdata <= dmem[mem_addr[7:2]];
    end
  end

  // reference model state: winner history, locked-run length, forced-CPU flag, pending read
  bit            m_last_dbg;
  int            m_run;
  bit            m_force;
  bit            m_pv, m_po_dbg;
  logic [DW-1:0] m_pd;
  logic [DW-1:0] refmem [0:63];

  logic          s_cpu_gnt, s_dbg_gnt, s_stall, s_cpu_rvalid, s_dbg_rvalid;
  logic [DW-1:0] s_cpu_rdata, s_dbg_rdata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle_check();
    bit            ec, ed, ewe;
    logic [AW-1:0] ea;
    logic [DW-1:0] ewd;
    bit            ecv, edv;
    @(negedge clk);
    if (reset)                  begin ec = 0; ed = 0; end
    else if (m_force)           begin ec = cpu_req; ed = dbg_req & ~cpu_req; end
    else if (m_run > 0)         begin ec = 0; ed = dbg_req; end
    else if (cpu_req & dbg_req) begin ec = m_last_dbg; ed = ~m_last_dbg; end
    else                        begin ec = cpu_req; ed = dbg_req; end
    ewe = ec ? cpu_we : (ed ? dbg_we : 1'b0);
    ea  = ec ? cpu_addr : (ed ? dbg_addr : '0);
    ewd = ec ? cpu_wdata : (ed ? dbg_wdata : '0);
    ecv = !reset && m_pv && !m_po_dbg;
    edv = !reset && m_pv && m_po_dbg;

    s_cpu_gnt = cpu_gnt; s_dbg_gnt = dbg_gnt; s_stall = cpu_stall;
    s_cpu_rvalid = cpu_rvalid; s_dbg_rvalid = dbg_rvalid;
    s_cpu_rdata = cpu_rdata; s_dbg_rdata = dbg_rdata;

    chk("cpu_gnt", cpu_gnt, ec);
    chk("dbg_gnt", dbg_gnt, ed);
    chk("cpu_stall", cpu_stall, cpu_req & ~ec);
    chk("mem_en", mem_en, ec | ed);
    chk("mem_we", mem_we, ewe);
    chk("mem_addr", mem_addr, ea);
    chk("mem_wdata", mem_wdata, ewd);
    chk("cpu_rvalid", cpu_rvalid, ecv);
    chk("dbg_rvalid", dbg_rvalid, edv);
    chk("cpu_rdata", cpu_rdata, ecv ? m_pd : '0);
    chk("dbg_rdata", dbg_rdata, edv ? m_pd : '0);

    if (reset) begin
      m_last_dbg = 1; m_run = 0; m_force = 0; m_pv = 0;
    end else begin
      m_pv = (ec | ed) & ~ewe;
      m_po_dbg = ed;
      m_pd = refmem[ea[7:2]];
      if ((ec | ed) && ewe) refmem[ea[7:2]] = ewd;
      if (ec | ed) m_last_dbg = ed;
      if (m_force) begin
        m_force = 0;
      end else if (ed && (m_run > 0 || dbg_lock)) begin
        m_run++;
        if (m_run == LM) begin m_force = 1; m_run = 0; end
        else if (!dbg_lock) m_run = 0;
      end else if (m_run > 0 && !dbg_req) begin
        m_run = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cpu(input bit req, input bit we, input int addr, input logic [DW-1:0] wd);
    cpu_req = req; cpu_we = we; cpu_addr = AW'(addr); cpu_wdata = wd;
  endtask

  task automatic drive_dbg(input bit req, input bit we, input bit lock, input int addr,
                           input logic [DW-1:0] wd);
    dbg_req = req; dbg_we = we; dbg_lock = lock; dbg_addr = AW'(addr); dbg_wdata = wd;
  endtask

  typedef struct {
    bit rst, creq, dreq;
    bit ecg, edg;
  } vec_t;

  vec_t tbl [8];

  initial begin
    tbl[0] = '{1, 1, 1, 0, 0};
    tbl[1] = '{1, 1, 1, 0, 0};
    tbl[2] = '{0, 1, 1, 1, 0};
    tbl[3] = '{0, 1, 1, 0, 1};
    tbl[4] = '{0, 1, 1, 1, 0};
    tbl[5] = '{0, 1, 1, 0, 1};
    tbl[6] = '{0, 1, 0, 1, 0};
    tbl[7] = '{0, 0, 1, 0, 1};

    for (int i = 0; i < 64; i++) refmem[i] = '0;
    m_last_dbg = 1; m_run = 0; m_force = 0; m_pv = 0; m_po_dbg = 0; m_pd = '0;
    mem_clear = 1'b1;
    reset = 1'b1;
    drive_cpu(0, 0, 0, 0);
    drive_dbg(0, 0, 0, 0, 0);

    for (int i = 0; i < 8; i++) begin
      reset = tbl[i].rst;
      drive_cpu(tbl[i].creq, 1, 8, 32'h11);
      drive_dbg(tbl[i].dreq, 1, 0, 12, 32'h22);
      cycle_check();
      mem_clear = 1'b0;
      chk($sformatf("tbl%0d_cpu_gnt", i), s_cpu_gnt, tbl[i].ecg);
      chk($sformatf("tbl%0d_dbg_gnt", i), s_dbg_gnt, tbl[i].edg);
      chk($sformatf("tbl%0d_stall", i), s_stall, tbl[i].creq & ~tbl[i].ecg);
    end

    // CPU writes 7 to 96, debug reads it back
    drive_cpu(1, 1, 96, 7); drive_dbg(0, 0, 0, 0, 0); cycle_check();
    drive_cpu(0, 0, 0, 0);  drive_dbg(1, 0, 0, 96, 0); cycle_check();
    chk("rd96_dbg_gnt", s_dbg_gnt, 1);
    drive_dbg(0, 0, 0, 0, 0); cycle_check();
    chk("rd96_dbg_rvalid", s_dbg_rvalid, 1);
    chk("rd96_dbg_rdata", s_dbg_rdata, 7);
    chk("rd96_cpu_rvalid", s_cpu_rvalid, 0);

    // locked debug burst of 12 against a busy CPU
    drive_cpu(1, 0, 0, 0); cycle_check();
    for (int i = 0; i < 12; i++) begin
      drive_cpu(1, 1, 200, 5);
      drive_dbg(1, 1, 1, 16, DW'(i));
      cycle_check();
      chk($sformatf("burst%0d_dbg_gnt", i), s_dbg_gnt, (i != 8));
      chk($sformatf("burst%0d_cpu_gnt", i), s_cpu_gnt, (i == 8));
    end

    // locked debug read then reset: rvalid dropped, lock gone
    drive_cpu(0, 0, 0, 0); drive_dbg(1, 0, 1, 96, 0); cycle_check();
    chk("rst_rd_gnt", s_dbg_gnt, 1);
    reset = 1'b1; drive_dbg(0, 0, 0, 0, 0); cycle_check();
    chk("rst_dbg_rvalid", s_dbg_rvalid, 0);
    reset = 1'b0; drive_cpu(1, 0, 100, 0); drive_dbg(1, 0, 1, 96, 0); cycle_check();
    chk("rst_after_cpu_gnt", s_cpu_gnt, 1);
    chk("rst_after_dbg_gnt", s_dbg_gnt, 0);
    drive_cpu(0, 0, 0, 0); drive_dbg(1, 0, 0, 96, 0); cycle_check();
    drive_dbg(0, 0, 0, 0, 0); cycle_check();

    // CPU read of 100 followed by debug write 25 to 100
    drive_cpu(1, 1, 100, 32'h55); cycle_check();
    drive_cpu(1, 0, 100, 0); cycle_check();
    drive_cpu(0, 0, 0, 0); drive_dbg(1, 1, 0, 100, 25); cycle_check();
    chk("raw_old_rvalid", s_cpu_rvalid, 1);
    chk("raw_old_rdata", s_cpu_rdata, 32'h55);
    drive_dbg(0, 0, 0, 0, 0); drive_cpu(1, 0, 100, 0); cycle_check();
    drive_cpu(0, 0, 0, 0); cycle_check();
    chk("raw_new_rdata", s_cpu_rdata, 25);

    // randomized traffic with hold-until-grant handshake
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 199) == 0);
      if (!cpu_req || s_cpu_gnt)
        drive_cpu($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 63) * 4, $urandom);
      if (!dbg_req || s_dbg_gnt)
        drive_dbg($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 1'b0,
                  $urandom_range(0, 63) * 4, $urandom);
      dbg_lock = ($urandom_range(0, 4) != 0);
      cycle_check();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
